// File: rtl/sprite_palette_if.sv
// Pixel stream, index-memory write and palette readback signals of the sprite palette encoder.
// The master side feeds pixels and reads the palette; the slave side is the encoder.
interface sprite_palette_if;
    logic       Start;
    logic       PixValid;
    logic       PixReady;
    logic [7:0] PixR;
    logic [7:0] PixG;
    logic [7:0] PixB;
    logic       WrEn;
    logic [9:0] WrX;
    logic [9:0] WrY;
    logic [2:0] WrIdxR;
    logic [2:0] WrIdxG;
    logic [2:0] WrIdxB;
    logic [2:0] PalRdIdx;
    logic [7:0] PalR;
    logic [7:0] PalG;
    logic [7:0] PalB;
    logic [3:0] PalCntR;
    logic [3:0] PalCntG;
    logic [3:0] PalCntB;
    logic       Busy;
    logic       Done;
    logic       Overflow;

    modport master (
        output Start, PixValid, PixR, PixG, PixB, PalRdIdx,
        input  PixReady, WrEn, WrX, WrY, WrIdxR, WrIdxG, WrIdxB,
               PalR, PalG, PalB, PalCntR, PalCntG, PalCntB, Busy, Done, Overflow
    );

    modport slave (
        input  Start, PixValid, PixR, PixG, PixB, PalRdIdx,
        output PixReady, WrEn, WrX, WrY, WrIdxR, WrIdxG, WrIdxB,
               PalR, PalG, PalB, PalCntR, PalCntG, PalCntB, Busy, Done, Overflow
    );
endinterface

// File: rtl/sprite_palette_encoder.sv
// Encodes a raster-order sprite into per-channel palette indices, building an independent
// first-come palette for R, G and B while streaming index writes one cycle after each pixel.
module sprite_palette_encoder #(
    parameter int WIDTH     = 20,
    parameter int HEIGHT    = 20,
    parameter int PAL_DEPTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    sprite_palette_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);
    localparam logic [3:0] DEPTH  = 4'(PAL_DEPTH);

    state_t               state_q, state_d;
    logic [2:0][7:0][7:0] pal_q, pal_d;
    logic [2:0][3:0]      cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [9:0]           x_q, x_d;
    logic [9:0]           y_q, y_d;
    logic                 wr_en_q, wr_en_d;
    logic [9:0]           wr_x_q, wr_x_d;
    logic [9:0]           wr_y_q, wr_y_d;
    logic [2:0][2:0]      wr_idx_q, wr_idx_d;

    logic                 accept_s;
    logic [2:0][7:0]      pix_s;
    logic [2:0]           hit_s;
    logic [2:0][2:0]      hit_idx_s;

    assign pix_s    = {bus.PixB, bus.PixG, bus.PixR};
    assign accept_s = (state_q == ST_ENCODE) && bus.PixValid;

    // Lowest populated entry equal to the incoming value; scanning downwards lets the lowest win.
    always_comb begin
        hit_s     = 3'b000;
        hit_idx_s = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 7; i >= 0; i--) begin
                if ((4'(i) < cnt_q[ch]) && (pal_q[ch][i] == pix_s[ch])) begin
                    hit_s[ch]     = 1'b1;
                    hit_idx_s[ch] = 3'(i);
                end else begin
                end
            end
        end
    end

    // Next-state, palette update, raster counters and index-write staging.
    always_comb begin
        state_d  = state_q;
        pal_d    = pal_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        x_d      = x_q;
        y_d      = y_q;
        wr_en_d  = 1'b0;
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        wr_idx_d = wr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_ENCODE;
                    pal_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    x_d     = 10'd0;
                    y_d     = 10'd0;
                end else begin
                end
            end
            ST_ENCODE: begin
                if (accept_s) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        if (hit_s[ch]) begin
                            wr_idx_d[ch] = hit_idx_s[ch];
                        end else if (cnt_q[ch] < DEPTH) begin
                            pal_d[ch][cnt_q[ch][2:0]] = pix_s[ch];
                            wr_idx_d[ch]              = cnt_q[ch][2:0];
                            cnt_d[ch]                 = cnt_q[ch] + 4'd1;
                        end else begin
                            // Palette full: emit index 0, keep the palette, and flag overflow.
                            wr_idx_d[ch] = 3'd0;
                            ovf_d        = 1'b1;
                        end
                    end
                    wr_en_d = 1'b1;
                    wr_x_d  = x_q;
                    wr_y_d  = y_q;
                    if (x_q == X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == Y_LAST) begin
                            y_d     = 10'd0;
                            state_d = ST_DONE;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end else begin
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            pal_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            wr_en_q  <= 1'b0;
            wr_x_q   <= 10'd0;
            wr_y_q   <= 10'd0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            pal_q    <= pal_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wr_en_q  <= wr_en_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    assign bus.PixReady = (state_q == ST_ENCODE);
    assign bus.Busy     = (state_q == ST_ENCODE);
    assign bus.Done     = (state_q == ST_DONE);
    assign bus.Overflow = ovf_q;
    assign bus.WrEn     = wr_en_q;
    assign bus.WrX      = wr_x_q;
    assign bus.WrY      = wr_y_q;
    assign bus.WrIdxR   = wr_idx_q[0];
    assign bus.WrIdxG   = wr_idx_q[1];
    assign bus.WrIdxB   = wr_idx_q[2];
    assign bus.PalCntR  = cnt_q[0];
    assign bus.PalCntG  = cnt_q[1];
    assign bus.PalCntB  = cnt_q[2];

    // Readback of an unpopulated slot returns 0 rather than stale data.
    assign bus.PalR = ({1'b0, bus.PalRdIdx} < cnt_q[0]) ? pal_q[0][bus.PalRdIdx] : 8'd0;
    assign bus.PalG = ({1'b0, bus.PalRdIdx} < cnt_q[1]) ? pal_q[1][bus.PalRdIdx] : 8'd0;
    assign bus.PalB = ({1'b0, bus.PalRdIdx} < cnt_q[2]) ? pal_q[2][bus.PalRdIdx] : 8'd0;
endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Self-checking bench: a 2x2 encoder and a default 20x20 encoder driven with directed and random
// pixels; expected index writes come from a list-based palette model of the encoding rules.
module tb_sprite_palette_encoder;
    localparam int DEPTH = 8;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] ir;
        logic [2:0] ig;
        logic [2:0] ib;
        bit         last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sprite_palette_if bs();
    sprite_palette_if bb();

    sprite_palette_encoder #(.WIDTH(2), .HEIGHT(2), .PAL_DEPTH(8)) dut_s (
        .Clk(clk), .Reset_n(rst_n), .bus(bs)
    );
    sprite_palette_encoder dut_b (
        .Clk(clk), .Reset_n(rst_n), .bus(bb)
    );

    exp_t       exp_s[$];
    exp_t       exp_b[$];
    exp_t       e_s;
    exp_t       e_b;
    logic [7:0] pal_m [2][3][DEPTH];
    int         cnt_m [2][3];
    int         n_m [2];
    int         wren_s, wren_b, done_s, done_b;
    logic [9:0] last_x_b, last_y_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string pfx(input int d);
        return (d == 0) ? "s" : "b";
    endfunction

    function automatic logic [7:0] rv(input int hi);
        return 8'($urandom_range(0, hi));
    endfunction

    // Palette model: search the list of seen values, append while room remains, else flag.
    function automatic void model_pix(input int d, input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
        exp_t       e;
        logic [7:0] v [3];
        logic [2:0] ix [3];
        int         w;
        int         h;
        w = (d == 0) ? 2 : 20;
        h = (d == 0) ? 2 : 20;
        v = '{r, g, b};
        for (int c = 0; c < 3; c++) begin
            int f;
            f = -1;
            for (int i = 0; i < cnt_m[d][c]; i++)
                if (f < 0 && pal_m[d][c][i] == v[c]) f = i;
            if (f >= 0) ix[c] = 3'(f);
            else if (cnt_m[d][c] < DEPTH) begin
                pal_m[d][c][cnt_m[d][c]] = v[c];
                ix[c] = 3'(cnt_m[d][c]);
                cnt_m[d][c]++;
            end else ix[c] = 3'd0;
        end
        e.x  = 10'(n_m[d] % w);
        e.y  = 10'(n_m[d] / w);
        e.ir = ix[0];
        e.ig = ix[1];
        e.ib = ix[2];
        n_m[d]++;
        e.last = (n_m[d] == w * h);
        if (d == 0) exp_s.push_back(e);
        else exp_b.push_back(e);
    endfunction

    task automatic set_pix(input int d, input logic v, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
        if (d == 0) begin
            bs.PixValid = v; bs.PixR = r; bs.PixG = g; bs.PixB = b;
        end else begin
            bb.PixValid = v; bb.PixR = r; bb.PixG = g; bb.PixB = b;
        end
    endtask

    task automatic start(input int d);
        if (d == 0) bs.Start = 1'b1; else bb.Start = 1'b1;
        tick();
        bs.Start = 1'b0;
        bb.Start = 1'b0;
        n_m[d] = 0;
        for (int c = 0; c < 3; c++) cnt_m[d][c] = 0;
        check_val({pfx(d), "_start_busy"}, (d == 0) ? bs.Busy : bb.Busy, 1);
        check_val({pfx(d), "_start_cntr"}, (d == 0) ? bs.PalCntR : bb.PalCntR, 0);
        check_val({pfx(d), "_start_cntg"}, (d == 0) ? bs.PalCntG : bb.PalCntG, 0);
        check_val({pfx(d), "_start_ovf"}, (d == 0) ? bs.Overflow : bb.Overflow, 0);
    endtask

    task automatic pix(input int d, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input int gap);
        for (int k = 0; k < gap; k++) begin
            set_pix(d, 1'b0, rv(255), rv(255), rv(255));
            tick();
        end
        set_pix(d, 1'b1, r, g, b);
        check_val({pfx(d), "_pixready"}, (d == 0) ? bs.PixReady : bb.PixReady, 1);
        model_pix(d, r, g, b);
        tick();
        set_pix(d, 1'b0, r, g, b);
    endtask

    // Called right after the last accepted pixel: one DONE cycle, then IDLE ignores pixels.
    task automatic frame_end(input int d);
        check_val({pfx(d), "_done_pulse"}, (d == 0) ? bs.Done : bb.Done, 1);
        check_val({pfx(d), "_done_busy"}, (d == 0) ? bs.Busy : bb.Busy, 0);
        check_val({pfx(d), "_done_ready"}, (d == 0) ? bs.PixReady : bb.PixReady, 0);
        set_pix(d, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        tick();
        check_val({pfx(d), "_idle_done"}, (d == 0) ? bs.Done : bb.Done, 0);
        check_val({pfx(d), "_idle_ready"}, (d == 0) ? bs.PixReady : bb.PixReady, 0);
        set_pix(d, 1'b0, 8'd0, 8'd0, 8'd0);
        tick();
    endtask

    // Index-write monitors for both encoders.
    always @(negedge clk) begin
        if (bs.WrEn === 1'b1) begin
            wren_s++;
            if (exp_s.size() == 0) check_val("s_unexpected_wren", 1, 0);
            else begin
                e_s = exp_s.pop_front();
                check_val("s_wrx", bs.WrX, e_s.x);
                check_val("s_wry", bs.WrY, e_s.y);
                check_val("s_idxr", bs.WrIdxR, e_s.ir);
                check_val("s_idxg", bs.WrIdxG, e_s.ig);
                check_val("s_idxb", bs.WrIdxB, e_s.ib);
                check_val("s_done_with_wren", bs.Done, e_s.last);
            end
        end else if (bs.Done === 1'b1) check_val("s_stray_done", bs.Done, 0);
        if (bs.Done === 1'b1) done_s++;
        if (bb.WrEn === 1'b1) begin
            wren_b++;
            last_x_b = bb.WrX;
            last_y_b = bb.WrY;
            if (exp_b.size() == 0) check_val("b_unexpected_wren", 1, 0);
            else begin
                e_b = exp_b.pop_front();
                check_val("b_wrx", bb.WrX, e_b.x);
                check_val("b_wry", bb.WrY, e_b.y);
                check_val("b_idxr", bb.WrIdxR, e_b.ir);
                check_val("b_idxg", bb.WrIdxG, e_b.ig);
                check_val("b_idxb", bb.WrIdxB, e_b.ib);
                check_val("b_done_with_wren", bb.Done, e_b.last);
            end
        end else if (bb.Done === 1'b1) check_val("b_stray_done", bb.Done, 0);
        if (bb.Done === 1'b1) done_b++;
    end

    initial begin
        int w0;
        int d0;
        n_checks = 0; n_errors = 0;
        wren_s = 0; wren_b = 0; done_s = 0; done_b = 0;
        rst_n = 1'b1;
        bs.Start = 1'b0; bb.Start = 1'b0;
        bs.PalRdIdx = 3'd0; bb.PalRdIdx = 3'd0;
        set_pix(0, 1'b0, 8'd0, 8'd0, 8'd0);
        set_pix(1, 1'b0, 8'd0, 8'd0, 8'd0);
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_val("rst_ready", bb.PixReady, 0);
        check_val("rst_busy", bb.Busy, 0);
        check_val("rst_wren", bb.WrEn, 0);
        check_val("rst_done", bs.Done, 0);
        check_val("rst_cntr", bb.PalCntR, 0);
        check_val("rst_ovf", bb.Overflow, 0);
        rst_n = 1'b1;
        tick();

        // Directed 2x2 frame with a known palette outcome.
        start(0);
        pix(0, 8'd10, 8'd20, 8'd30, 0);
        pix(0, 8'd10, 8'd20, 8'd30, 0);
        pix(0, 8'd40, 8'd20, 8'd30, 0);
        pix(0, 8'd10, 8'd50, 8'd30, 0);
        frame_end(0);
        check_val("s_cntr", bs.PalCntR, 2);
        check_val("s_cntg", bs.PalCntG, 2);
        check_val("s_cntb", bs.PalCntB, 1);
        check_val("s_wren_count", wren_s, 4);
        check_val("s_done_count", done_s, 1);
        bs.PalRdIdx = 3'd1;
        #1;
        check_val("s_palr1", bs.PalR, 40);
        check_val("s_palg1", bs.PalG, 50);
        check_val("s_palb1", bs.PalB, 0);
        bs.PalRdIdx = 3'd0;
        #1;
        check_val("s_palb0", bs.PalB, 30);
        bs.PalRdIdx = 3'd2;
        #1;
        check_val("s_palr2", bs.PalR, 0);

        // Red palette overflow on the ninth distinct value, with a Start pulse mid-frame.
        w0 = wren_b; d0 = done_b;
        start(1);
        for (int v = 0; v < 9; v++) begin
            pix(1, 8'(v), 8'd0, 8'd0, 0);
            if (v == 7) begin
                check_val("b_ovf_at_8", bb.Overflow, 0);
                check_val("b_cntr_at_8", bb.PalCntR, 8);
            end
        end
        check_val("b_ovf_at_9", bb.Overflow, 1);
        for (int k = 9; k < 400; k++) begin
            if (k == 50) begin
                bb.Start = 1'b1;
                tick();
                bb.Start = 1'b0;
                check_val("b_start_ignored_busy", bb.Busy, 1);
                check_val("b_start_ignored_cnt", bb.PalCntR, 8);
                check_val("b_start_ignored_ovf", bb.Overflow, 1);
            end
            pix(1, rv(11), rv(11), rv(5), 0);
        end
        frame_end(1);
        repeat (3) tick();
        check_val("b_ovf_held", bb.Overflow, 1);
        check_val("b_cntr_held", bb.PalCntR, 8);
        check_val("b_idle_busy", bb.Busy, 0);
        bb.PalRdIdx = 3'd3;
        #1;
        check_val("b_palr3", bb.PalR, 3);
        check_val("b_ovf_wren_count", wren_b - w0, 400);
        check_val("b_ovf_done_count", done_b - d0, 1);

        // Full default frame with PixValid toggling every other cycle.
        w0 = wren_b; d0 = done_b;
        start(1);
        for (int k = 0; k < 400; k++) pix(1, rv(6), rv(6), rv(6), 1);
        frame_end(1);
        check_val("b_frame_wren_count", wren_b - w0, 400);
        check_val("b_frame_done_count", done_b - d0, 1);
        check_val("b_last_x", last_x_b, 19);
        check_val("b_last_y", last_y_b, 19);
        check_val("b_after_busy", bb.Busy, 0);
        check_val("b_no_ovf", bb.Overflow, 0);

        // Reset at the fifth pixel abandons the frame.
        start(1);
        for (int k = 0; k < 4; k++) pix(1, rv(20), rv(20), rv(20), 0);
        set_pix(1, 1'b1, 8'd7, 8'd7, 8'd7);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_wren", bb.WrEn, 0);
        check_val("mid_rst_ready", bb.PixReady, 0);
        check_val("mid_rst_busy", bb.Busy, 0);
        check_val("mid_rst_wrx", bb.WrX, 0);
        check_val("mid_rst_idx", {bb.WrIdxR, bb.WrIdxG, bb.WrIdxB}, 0);
        check_val("mid_rst_cnt", bb.PalCntR, 0);
        exp_b.delete();
        w0 = wren_b; d0 = done_b;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_val("post_rst_ready", bb.PixReady, 0);
        check_val("post_rst_wren_count", wren_b - w0, 0);
        check_val("post_rst_done_count", done_b - d0, 0);
        set_pix(1, 1'b0, 8'd0, 8'd0, 8'd0);
        start(1);
        for (int k = 0; k < 400; k++) pix(1, rv(9), rv(9), rv(9), 0);
        frame_end(1);
        check_val("restart_wren_count", wren_b - w0, 400);

        check_val("s_exp_empty", exp_s.size(), 0);
        check_val("b_exp_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
